// File: rtl/updown_count_display.sv
// updown_count_display
// Consumes the 4-bit up/down counter value and direction, drives one
// 7-segment digit plus a direction LED, flags modulo-16 wraps with a
// one-cycle pulse, keeps a signed wrap epoch and flashes the digit for
// FLASH_CYCLES cycles after each wrap.
// Optional build macro: HEX_ALPHA_EN (show A,b,C,d,E,F for 10..15;
// without it those values show a dash).
module updown_count_display #(
  parameter int FLASH_CYCLES   = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ud,
  input  logic [3:0] q,
  output logic [6:0] seg,
  output logic       dir_led,
  output logic       wrap_pulse,
  output logic [7:0] epoch
);

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    FLASH = 1'b1
  } state_t;

  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  state_t     state;
  state_t     state_next;
  logic [7:0] timer;
  logic [7:0] timer_next;
  logic [6:0] seg_next;
  logic [6:0] seg_pat;
  logic [6:0] seg_dec;
  logic [3:0] q_prev;
  logic       prev_valid;
  logic       up_wrap;
  logic       down_wrap;
  logic       wrap;

  // Wrap detection compares the live value with last cycle's sample; the
  // very first cycle after reset has no trustworthy previous value.
  always_comb begin
    up_wrap   = prev_valid & ud & (q_prev == 4'hF) & (q == 4'h0);
    down_wrap = prev_valid & ~ud & (q_prev == 4'h0) & (q == 4'hF);
    wrap      = up_wrap | down_wrap;
  end

  // Hex digit to active-high segment pattern {g,f,e,d,c,b,a}.
  always_comb begin
    seg_pat = 7'h40;
    case (q)
      4'h0: seg_pat = 7'h3F;
      4'h1: seg_pat = 7'h06;
      4'h2: seg_pat = 7'h5B;
      4'h3: seg_pat = 7'h4F;
      4'h4: seg_pat = 7'h66;
      4'h5: seg_pat = 7'h6D;
      4'h6: seg_pat = 7'h7D;
      4'h7: seg_pat = 7'h07;
      4'h8: seg_pat = 7'h7F;
      4'h9: seg_pat = 7'h6F;
`ifdef HEX_ALPHA_EN
      4'hA: seg_pat = 7'h77;
      4'hB: seg_pat = 7'h7C;
      4'hC: seg_pat = 7'h39;
      4'hD: seg_pat = 7'h5E;
      4'hE: seg_pat = 7'h79;
      4'hF: seg_pat = 7'h71;
`endif
      default: seg_pat = 7'h40;
    endcase
    seg_dec = (SEG_ACTIVE_LOW != 0) ? ~seg_pat : seg_pat;
  end

  // Next-state logic: a wrap always (re)starts the flash window and shows the
  // new value in the pulse cycle; inside the window odd timer values blank.
  always_comb begin
    state_next = state;
    timer_next = timer;
    seg_next   = seg_dec;
    case (state)
      SHOW: begin
        if (wrap) begin
          state_next = FLASH;
          timer_next = FLASH_LOAD;
        end
      end
      FLASH: begin
        if (wrap) begin
          timer_next = FLASH_LOAD;
        end else begin
          if (timer[0]) begin
            seg_next = SEG_BLANK;
          end
          if (timer == 8'd0) begin
            state_next = SHOW;
          end else begin
            timer_next = timer - 8'd1;
          end
        end
      end
      default: begin
        state_next = SHOW;
        timer_next = 8'd0;
      end
    endcase
  end

  // FSM state and flash timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SHOW;
      timer <= 8'd0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Input sampling and registered outputs, all one cycle behind the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_prev     <= 4'h0;
      prev_valid <= 1'b0;
      seg        <= SEG_BLANK;
      dir_led    <= 1'b0;
      wrap_pulse <= 1'b0;
      epoch      <= 8'h00;
    end else begin
      q_prev     <= q;
      prev_valid <= 1'b1;
      seg        <= seg_next;
      dir_led    <= ud;
      wrap_pulse <= wrap;
      if (up_wrap) begin
        epoch <= epoch + 8'd1;
      end else if (down_wrap) begin
        epoch <= epoch - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_updown_count_display.sv
// tb_updown_count_display
// Directed bench for updown_count_display with the default parameters
// (FLASH_CYCLES = 8, active-low segments). Honours HEX_ALPHA_EN when
// computing the expected pattern for 10..15.
module tb_updown_count_display;

  localparam logic [6:0] BLANK = 7'h7F;

  logic       clk;
  logic       rst_n;
  logic       ud;
  logic [3:0] q;
  logic [6:0] seg;
  logic       dir_led;
  logic       wrap_pulse;
  logic [7:0] epoch;

  int checks = 0;
  int errors = 0;

  updown_count_display #(
    .FLASH_CYCLES  (8),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ud        (ud),
    .q         (q),
    .seg       (seg),
    .dir_led   (dir_led),
    .wrap_pulse(wrap_pulse),
    .epoch     (epoch)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference active-low pattern for one hex digit.
  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
`ifdef HEX_ALPHA_EN
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
`endif
      default: p = 7'h40;
    endcase
    return ~p;
  endfunction

  // Drive one input pair on the falling edge, then wait until just after
  // the rising edge that samples it.
  task automatic applyStimulus(input logic [3:0] qv, input logic udv);
    @(negedge clk);
    q  = qv;
    ud = udv;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against its expected value.
  task automatic checkOutput(input string tag, input logic [6:0] exp_seg,
                             input logic exp_wrap, input logic [7:0] exp_epoch,
                             input logic exp_dir);
    checks++;
    assert (seg === exp_seg) else begin
      errors++;
      $error("[TB] FAIL %s seg observed %h expected %h", tag, seg, exp_seg);
    end
    checks++;
    assert (wrap_pulse === exp_wrap) else begin
      errors++;
      $error("[TB] FAIL %s wrap_pulse observed %b expected %b", tag, wrap_pulse, exp_wrap);
    end
    checks++;
    assert (epoch === exp_epoch) else begin
      errors++;
      $error("[TB] FAIL %s epoch observed %h expected %h", tag, epoch, exp_epoch);
    end
    checks++;
    assert (dir_led === exp_dir) else begin
      errors++;
      $error("[TB] FAIL %s dir_led observed %b expected %b", tag, dir_led, exp_dir);
    end
  endtask

  // Hold one value through a full flash window: blank on the first cycle
  // after the pulse and then on every other cycle.
  task automatic checkFlash(input string tag, input logic [3:0] qv, input logic udv,
                            input logic [7:0] exp_epoch);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(qv, udv);
      checkOutput(tag, (i % 2 == 0) ? BLANK : dec(qv), 1'b0, exp_epoch, udv);
    end
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0;
    ud    = 1'b0;
    q     = 4'h5;
    $display("[TB] start");

    // Reset held with q = 5.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", BLANK, 1'b0, 8'h00, 1'b0);

    // Release: the digit appears one cycle later.
    @(negedge clk);
    rst_n = 1'b1;
    q     = 4'h5;
    ud    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release", dec(4'h5), 1'b0, 8'h00, 1'b1);

    // Down wrap from epoch 0.
    applyStimulus(4'h1, 1'b0); checkOutput("dn_1", dec(4'h1), 1'b0, 8'h00, 1'b0);
    applyStimulus(4'h0, 1'b0); checkOutput("dn_0", dec(4'h0), 1'b0, 8'h00, 1'b0);
    applyStimulus(4'hF, 1'b0); checkOutput("dn_wrap", dec(4'hF), 1'b1, 8'hFF, 1'b0);
    checkFlash("dn_flash", 4'hE, 1'b0, 8'hFF);
    applyStimulus(4'hE, 1'b0); checkOutput("dn_steady", dec(4'hE), 1'b0, 8'hFF, 1'b0);

    // Up wrap, epoch FF rolls to 00.
    applyStimulus(4'hE, 1'b1); checkOutput("up_E", dec(4'hE), 1'b0, 8'hFF, 1'b1);
    applyStimulus(4'hF, 1'b1); checkOutput("up_F", dec(4'hF), 1'b0, 8'hFF, 1'b1);
    applyStimulus(4'h0, 1'b1); checkOutput("up_wrap", dec(4'h0), 1'b1, 8'h00, 1'b1);
    checkFlash("up_flash", 4'h1, 1'b1, 8'h00);
    applyStimulus(4'h1, 1'b1); checkOutput("up_steady", dec(4'h1), 1'b0, 8'h00, 1'b1);

    // Non-wrap transitions: jump, hold at F, F->0 against direction.
    applyStimulus(4'h3, 1'b1); checkOutput("nw_3", dec(4'h3), 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h9, 1'b1); checkOutput("nw_jump", dec(4'h9), 1'b0, 8'h00, 1'b1);
    applyStimulus(4'hF, 1'b1); checkOutput("nw_F", dec(4'hF), 1'b0, 8'h00, 1'b1);
    applyStimulus(4'hF, 1'b1); checkOutput("nw_hold", dec(4'hF), 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, 1'b0); checkOutput("nw_mis", dec(4'h0), 1'b0, 8'h00, 1'b0);
    applyStimulus(4'h0, 1'b0); checkOutput("nw_show", dec(4'h0), 1'b0, 8'h00, 1'b0);

    // Back-to-back: up wrap, down wrap four cycles later reloads the timer.
    applyStimulus(4'hF, 1'b1); checkOutput("bb_0toF", dec(4'hF), 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, 1'b1); checkOutput("bb_up", dec(4'h0), 1'b1, 8'h01, 1'b1);
    applyStimulus(4'h0, 1'b1); checkOutput("bb_f1", BLANK, 1'b0, 8'h01, 1'b1);
    applyStimulus(4'h0, 1'b1); checkOutput("bb_f2", dec(4'h0), 1'b0, 8'h01, 1'b1);
    applyStimulus(4'h0, 1'b0); checkOutput("bb_f3", BLANK, 1'b0, 8'h01, 1'b0);
    applyStimulus(4'hF, 1'b0); checkOutput("bb_dn", dec(4'hF), 1'b1, 8'h00, 1'b0);
    checkFlash("bb_flash", 4'hF, 1'b0, 8'h00);
    applyStimulus(4'hF, 1'b0); checkOutput("bb_steady", dec(4'hF), 1'b0, 8'h00, 1'b0);

    // Reset asserted three cycles into a flash window.
    applyStimulus(4'h0, 1'b1); checkOutput("mr_wrap", dec(4'h0), 1'b1, 8'h01, 1'b1);
    applyStimulus(4'h0, 1'b1); checkOutput("mr_f1", BLANK, 1'b0, 8'h01, 1'b1);
    applyStimulus(4'h0, 1'b1); checkOutput("mr_f2", dec(4'h0), 1'b0, 8'h01, 1'b1);
    applyStimulus(4'h0, 1'b1); checkOutput("mr_f3", dec(4'h0) ^ dec(4'h0) ^ BLANK, 1'b0, 8'h01, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_async", BLANK, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    q     = 4'h2;
    ud    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mr_release", dec(4'h2), 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'h2, 1'b1);
      checkOutput("mr_steady", dec(4'h2), 1'b0, 8'h00, 1'b1);
    end

    // First cycle after release cannot detect a wrap even for 0 -> F down.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("pv_reset", BLANK, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    q     = 4'hF;
    ud    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pv_first", dec(4'hF), 1'b0, 8'h00, 1'b0);
    applyStimulus(4'hF, 1'b0); checkOutput("pv_hold", dec(4'hF), 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
